// File: rtl/bank_isu_credit_sched.sv
// Credit-gated round-robin scheduler from three ISU issue queues into a single
// registered SC issue slot, with one credit counter per xbar channel.
module bank_isu_credit_sched #(
  parameter int unsigned CREDIT_W    = 3,
  parameter int unsigned CREDIT_INIT = 4,
  parameter int unsigned PAYLOAD_W   = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [2:0]             req_valid_i,
  output logic [2:0]             req_ready_o,
  input  logic [3*PAYLOAD_W-1:0] req_payload_i,
  input  logic [2:0]             credit_return_i,
  output logic                   isu_sc_valid_o,
  input  logic                   isu_sc_ready_i,
  output logic [1:0]             isu_sc_channel_id_o,
  output logic [PAYLOAD_W-1:0]   isu_sc_payload_o,
  output logic [3*CREDIT_W-1:0]  credit_cnt_o,
  output logic                   credit_err_o
);

  localparam int unsigned NCH = 3;

  logic [CREDIT_W-1:0]  credit_q [NCH];
  logic [CREDIT_W-1:0]  credit_d [NCH];
  logic [1:0]           last_q, last_d;
  logic                 valid_q, valid_d;
  logic [1:0]           chan_q, chan_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic                 err_q, err_d;

  logic                 slot_free;
  logic [NCH-1:0]       eligible;
  logic [NCH-1:0]       grant;
  logic                 grant_any;
  logic [1:0]           grant_idx;
  logic [1:0]           cand [NCH];

  assign slot_free = ~valid_q | isu_sc_ready_i;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NCH; i++) begin
      eligible[i] = req_valid_i[i] & (credit_q[i] != '0);
    end
  end

  // Search order starts just after the last winner and wraps back to it.
  always_comb begin
    cand[0] = 2'd0;
    cand[1] = 2'd1;
    cand[2] = 2'd2;
    case (last_q)
      2'd0: begin cand[0] = 2'd1; cand[1] = 2'd2; cand[2] = 2'd0; end
      2'd1: begin cand[0] = 2'd2; cand[1] = 2'd0; cand[2] = 2'd1; end
      default: begin cand[0] = 2'd0; cand[1] = 2'd1; cand[2] = 2'd2; end
    endcase
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    if (slot_free) begin
      for (int k = 0; k < NCH; k++) begin
        if (!grant_any && eligible[cand[k]]) begin
          grant_any = 1'b1;
          grant_idx = cand[k];
        end
      end
    end
    grant = grant_any ? (NCH'(1) << grant_idx) : '0;
  end

  assign req_ready_o = grant;

  always_comb begin
    valid_d   = valid_q;
    chan_d    = chan_q;
    payload_d = payload_q;
    last_d    = last_q;
    err_d     = err_q;
    for (int i = 0; i < NCH; i++) begin
      credit_d[i] = credit_q[i];
    end

    if (grant_any) begin
      valid_d = 1'b1;
      chan_d  = grant_idx;
      last_d  = grant_idx;
      for (int i = 0; i < NCH; i++) begin
        if (grant_idx == 2'(i)) begin
          payload_d = req_payload_i[i*PAYLOAD_W +: PAYLOAD_W];
        end
      end
    end else if (valid_q && isu_sc_ready_i) begin
      valid_d = 1'b0;
    end

    // Return and consume on the same channel cancel; a return into a full counter is an overflow.
    for (int i = 0; i < NCH; i++) begin
      if (credit_return_i[i] && !grant[i]) begin
        if (credit_q[i] >= CREDIT_W'(CREDIT_INIT)) begin
          err_d = 1'b1;
        end else begin
          credit_d[i] = credit_q[i] + CREDIT_W'(1);
        end
      end else if (!credit_return_i[i] && grant[i]) begin
        credit_d[i] = credit_q[i] - CREDIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      chan_q    <= 2'd0;
      payload_q <= '0;
      last_q    <= 2'd2;
      err_q     <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        credit_q[i] <= CREDIT_W'(CREDIT_INIT);
      end
    end else begin
      valid_q   <= valid_d;
      chan_q    <= chan_d;
      payload_q <= payload_d;
      last_q    <= last_d;
      err_q     <= err_d;
      for (int i = 0; i < NCH; i++) begin
        credit_q[i] <= credit_d[i];
      end
    end
  end

  always_comb begin
    credit_cnt_o = '0;
    for (int i = 0; i < NCH; i++) begin
      credit_cnt_o[i*CREDIT_W +: CREDIT_W] = credit_q[i];
    end
  end

  assign isu_sc_valid_o      = valid_q;
  assign isu_sc_channel_id_o = chan_q;
  assign isu_sc_payload_o    = payload_q;
  assign credit_err_o        = err_q;

endmodule
